sequential_divider: RTL
=======================

# sequential_divider

Iterative unsigned N-bit divider for the calculator arithmetic unit, the inverse operation to the array multiplier. It accepts a dividend and divisor on a start pulse and runs a restoring shift-subtract algorithm, one quotient bit per clock. It presents registered quotient, remainder and a one-cycle done pulse to the calculator control logic. Divide-by-zero is detected up front and completes in one cycle with a flag.

## Interface
- N, 32, operand, quotient and remainder width in bits (N ≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  N  dividend, unsigned; sampled on the accepting edge only
- B  input  N  divisor, unsigned; sampled on the accepting edge only
- Q  output  N  quotient, registered, held until the next completion
- R  output  N  remainder, registered, held until the next completion
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when Q/R/div_by_zero are updated
- div_by_zero  output  1  registered status of the last completed operation

## Operation
- States: IDLE, RUN.
- IDLE with start=1 and B≠0: load the dividend shift register with A and the divisor register with B. Clear the partial remainder (N+1 bits). Load the step counter with N. Go to RUN, busy=1.
- IDLE with start=1 and B=0: stay in IDLE. Set Q=all ones, R=A, div_by_zero=1, done=1.
- IDLE with start=0: no action. done=0.
- RUN step, once per edge:
  - trial = {rem[N-1:0], dividend MSB} − {0, divisor}, width N+1.
  - No borrow: rem=trial and shift 1 into the quotient LSB.
  - Borrow: rem={rem[N-1:0], dividend MSB} and shift 0 into the quotient LSB.
  - The dividend shifts left by one. The counter decrements.
- On the step where the counter goes 1→0:
  - Write the final quotient to Q and rem[N-1:0] to R.
  - div_by_zero=0, done=1, busy=0, state→IDLE.
- start is ignored while in RUN. A and B may change freely after the accepting edge.
- Results satisfy A = Q·B + R and R < B for all B≠0.
- Reset (asynchronous, any state, including mid-division):
  - state=IDLE and counter=0.
  - Q=0, R=0, busy=0, done=0, div_by_zero=0.
  - Any in-flight operation is discarded with no done pulse.

## Timing
- Accepting edge = edge 0.
- Normal division:
  - busy is high from after edge 0 through edge N.
  - Steps execute on edges 1..N.
  - Q, R and done update on edge N. done is high for exactly the cycle between edge N and edge N+1.
  - Latency: N cycles from start to done.
- Divide-by-zero: done is high in the cycle after edge 0. Latency: 1 cycle. busy never asserts.
- Back-to-back operation:
  - The earliest next accepting edge is N+1, when done is high and the state is IDLE.
  - done may therefore stay high across consecutive cycles only when back-to-back divide-by-zero requests are made.
- done is deasserted on the edge following its assertion unless a new divide-by-zero completes on that edge.
- Throughput: one division per N+1 cycles.

## Test plan
- N=32, A=100, B=7, start pulse → done exactly 32 cycles later with Q=14, R=2, div_by_zero=0; busy high 32 cycles.
- N=32, A=0xFFFFFFFF, B=1 → Q=0xFFFFFFFF, R=0. Then A=3, B=10 issued on the cycle done is high → Q=0, R=3 after 32 more cycles.
- N=32, A=5, B=0 → done one cycle later, Q=0xFFFFFFFF, R=5, div_by_zero=1, busy never high. The next valid division clears div_by_zero.
- Start with A=1000, B=3. Pulse start with A=9, B=9 at cycle 10 while busy → ignored; result Q=333, R=1 at cycle 32.
- Assert rst_n=0 at cycle 15 of an operation → all outputs 0 immediately and no done pulse. After release, 50/5 yields Q=10, R=0.
- N=8 build: 255/16 → Q=15, R=15 after 8 cycles. Random 1000-vector sweep checked against A = Q·B + R and R < B.

Source files
------------

// File: rtl/sequential_divider.sv
// sequential_divider: restoring shift-subtract unsigned divider, one quotient bit per clock
module sequential_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [N-1:0] dividend, divisor, quo, rem, quo_next, rem_next;
  logic [N:0] shifted, trial;
  logic [CW-1:0] cnt;
  logic borrow;
  // One restoring step; the stored remainder is always below the divisor, so its
  // (N+1)-th bit only ever exists transiently in the shifted value.
  always_comb begin
    shifted  = {rem, dividend[N-1]};
    trial    = shifted - {1'b0, divisor};
    borrow   = trial[N];
    rem_next = borrow ? shifted[N-1:0] : trial[N-1:0];
    quo_next = {quo[N-2:0], ~borrow};
  end
  // Control FSM and datapath: accept in IDLE, iterate N steps in RUN, register results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dividend    <= '0;
      divisor     <= '0;
      rem         <= '0;
      quo         <= '0;
      Q           <= '0;
      R           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && B == '0) begin
          Q           <= '1;
          R           <= A;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end else if (start) begin
          dividend <= A;
          divisor  <= B;
          rem      <= '0;
          quo      <= '0;
          cnt      <= CW'(N);
          busy     <= 1'b1;
          state    <= RUN;
        end
      end else begin
        rem      <= rem_next;
        quo      <= quo_next;
        dividend <= {dividend[N-2:0], 1'b0};
        cnt      <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          Q           <= quo_next;
          R           <= rem_next;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      end
    end
  end
endmodule
